// File: rtl/adc_scan_scheduler_if.sv
// Interface between the scan scheduler and the ADC/opamp Control FSM.
//
// Handshake (level based, one request at a time):
//   The scheduler raises exactly one req_* only while Control reports
//   ctrl_idle=1. Control acknowledges by dropping ctrl_idle; the scheduler
//   drops the request on that same edge. For a conversion, Control then
//   pulses data_ready once the result is readable, and the transaction is
//   complete when ctrl_idle returns to 1. A reconfig completes when
//   ctrl_idle returns to 1 after the acknowledge.
//
// Signals:
//   req_adc1, req_adc2, req_reconfig : scheduler -> Control, level requests
//   ctrl_idle                        : Control -> scheduler, Control waiting
//   data_ready                       : Control -> scheduler, result readable
interface adc_scan_scheduler_if;
  logic req_adc1;
  logic req_adc2;
  logic req_reconfig;
  logic ctrl_idle;
  logic data_ready;

  modport master (
    output req_adc1,
    output req_adc2,
    output req_reconfig,
    input  ctrl_idle,
    input  data_ready
  );

  modport slave (
    input  req_adc1,
    input  req_adc2,
    input  req_reconfig,
    output ctrl_idle,
    output data_ready
  );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Periodic ADC scan scheduler sitting on top of the ADC/opamp Control FSM.
// A timer schedules scans of the channels enabled in chan_mask (ADC1, then
// ADC2); reconfig requests are dispatched between scans; a watchdog abandons
// any sequence stuck too long in one state.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   enable         periodic scanning on
//   period         scan period in cycles (0 behaves as 1)
//   chan_mask      bit0 = ADC1, bit1 = ADC2, sampled when a scan starts
//   reconfig_req   1-cycle pulse requesting a reconfiguration
//   err_clr        1-cycle pulse clearing timeout_err and overrun
//   ctrl           handshake with Control (master side)
//   busy           FSM not idle
//   scan_done      1-cycle pulse when a scan completes
//   reconfig_done  1-cycle pulse when a reconfig completes
//   sample_cnt     number of completed scans (wraps)
//   timeout_err    sticky, watchdog fired
//   overrun        sticky, timer ticked while a scan was still pending
//   state_dbg      current FSM state encoding
module adc_scan_scheduler #(
  parameter int PERIOD_W = 16,
  parameter int TIMEOUT  = 50000,
  parameter int TO_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic [1:0]          chan_mask,
  input  logic                reconfig_req,
  input  logic                err_clr,
  adc_scan_scheduler_if.master ctrl,
  output logic                busy,
  output logic                scan_done,
  output logic                reconfig_done,
  output logic [15:0]         sample_cnt,
  output logic                timeout_err,
  output logic                overrun,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_R_REQ  = 3'd1,
    S_R_WAIT = 3'd2,
    S_C_REQ  = 3'd3,
    S_C_DATA = 3'd4,
    S_C_END  = 3'd5
  } state_t;

  // The forced exit happens on the edge where the counter would reach
  // TIMEOUT-1, so no state is occupied for more than TIMEOUT-1 cycles.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 2);

  state_t              state, state_d;
  logic [PERIOD_W-1:0] timer, period_m1;
  logic                tick;
  logic                scan_pend, rcfg_pend;
  logic [1:0]          mask_q, mask_d;
  logic                ch_q, ch_d;      // channel being converted: 0 = ADC1, 1 = ADC2
  logic [TO_W-1:0]     wd;
  logic                wd_fire;
  logic                scan_start, scan_fin, rcfg_fin;

  assign period_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign tick      = enable && (timer == period_m1);
  assign wd_fire   = (state != S_IDLE) && (wd == WD_LAST);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          timer <= '0;
    else if (!enable) timer <= '0;
    else if (tick)    timer <= '0;
    else              timer <= timer + PERIOD_W'(1);
  end

  always_comb begin
    state_d    = state;
    mask_d     = mask_q;
    ch_d       = ch_q;
    scan_start = 1'b0;
    scan_fin   = 1'b0;
    rcfg_fin   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ctrl.ctrl_idle) begin
          if (rcfg_pend) begin
            state_d = S_R_REQ;
          end else if (scan_pend) begin
            scan_start = 1'b1;
            mask_d     = chan_mask;
            if (chan_mask[0]) begin
              state_d = S_C_REQ;
              ch_d    = 1'b0;
            end else if (chan_mask[1]) begin
              state_d = S_C_REQ;
              ch_d    = 1'b1;
            end
          end
        end
      end
      S_R_REQ:  if (!ctrl.ctrl_idle) state_d = S_R_WAIT;
      S_R_WAIT: begin
        if (ctrl.ctrl_idle) begin
          state_d  = S_IDLE;
          rcfg_fin = 1'b1;
        end
      end
      S_C_REQ:  if (!ctrl.ctrl_idle) state_d = S_C_DATA;
      S_C_DATA: if (ctrl.data_ready) state_d = S_C_END;
      S_C_END: begin
        if (ctrl.ctrl_idle) begin
          if (!ch_q && mask_q[1]) begin
            state_d = S_C_REQ;
            ch_d    = 1'b1;
          end else begin
            state_d  = S_IDLE;
            scan_fin = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Watchdog overrides everything: abandoned work reports no completion.
    if (wd_fire) begin
      state_d  = S_IDLE;
      scan_fin = 1'b0;
      rcfg_fin = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      mask_q            <= '0;
      ch_q              <= 1'b0;
      ctrl.req_adc1     <= 1'b0;
      ctrl.req_adc2     <= 1'b0;
      ctrl.req_reconfig <= 1'b0;
      scan_done         <= 1'b0;
      reconfig_done     <= 1'b0;
      sample_cnt        <= '0;
      wd                <= '0;
    end else begin
      state             <= state_d;
      mask_q            <= mask_d;
      ch_q              <= ch_d;
      // Requests follow the next state so they rise on the entry edge
      // (when ctrl_idle was 1) and fall on the acknowledge edge.
      ctrl.req_adc1     <= (state_d == S_C_REQ) && !ch_d;
      ctrl.req_adc2     <= (state_d == S_C_REQ) && ch_d;
      ctrl.req_reconfig <= (state_d == S_R_REQ);
      scan_done         <= scan_fin;
      reconfig_done     <= rcfg_fin;
      if (scan_fin) sample_cnt <= sample_cnt + 16'd1;
      if ((state_d != state) || (state == S_IDLE)) wd <= '0;
      else                                         wd <= wd + TO_W'(1);
    end
  end

  // Pending flags and sticky errors: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_pend   <= 1'b0;
      rcfg_pend   <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (tick)            scan_pend <= 1'b1;
      else if (scan_start) scan_pend <= 1'b0;

      if (reconfig_req)  rcfg_pend <= 1'b1;
      else if (rcfg_fin) rcfg_pend <= 1'b0;

      if (tick && scan_pend) overrun <= 1'b1;
      else if (err_clr)      overrun <= 1'b0;

      if (wd_fire)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Testbench for adc_scan_scheduler: a cycle table with hand-computed
// outputs, then sequences against a small Control model for periodic
// scanning, reconfig deferral, watchdog, overrun and asynchronous reset.
module tb_adc_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] period = 16'd0;
  logic [1:0]  chan_mask = 2'b00;
  logic        reconfig_req = 1'b0;
  logic        err_clr = 1'b0;
  logic        busy, scan_done, reconfig_done, timeout_err, overrun;
  logic [15:0] sample_cnt;
  logic [2:0]  state_dbg;

  logic drv_idle = 1'b1;
  logic drv_dr = 1'b0;
  logic model_idle = 1'b1;
  logic model_dr = 1'b0;
  logic use_model = 1'b0;
  logic model_hang = 1'b0;
  int   model_dly = 10;
  int   m_phase = 0;
  int   m_cnt = 0;
  logic m_is_rc = 1'b0;

  int checks = 0;
  int failures = 0;

  adc_scan_scheduler_if bus ();
  assign bus.ctrl_idle  = use_model ? model_idle : drv_idle;
  assign bus.data_ready = use_model ? model_dr : drv_dr;

  adc_scan_scheduler #(.PERIOD_W(16), .TIMEOUT(50), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period),
    .chan_mask(chan_mask), .reconfig_req(reconfig_req), .err_clr(err_clr),
    .ctrl(bus), .busy(busy), .scan_done(scan_done),
    .reconfig_done(reconfig_done), .sample_cnt(sample_cnt),
    .timeout_err(timeout_err), .overrun(overrun), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Control model: acks 3 cycles after a request, pulses data_ready
  // model_dly cycles later, returns idle 2 cycles after that.
  // Reconfig: ack after 3 cycles, idle again 5 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (!use_model || rst) begin
        m_phase = 0; m_cnt = 0; model_idle = 1'b1; model_dr = 1'b0;
      end else begin
        case (m_phase)
          0: if (bus.req_adc1 || bus.req_adc2 || bus.req_reconfig) begin
               m_is_rc = bus.req_reconfig; m_phase = 1; m_cnt = 0;
             end
          1: begin
               m_cnt++;
               if (m_cnt == 3) begin model_idle = 1'b0; m_cnt = 0; m_phase = m_is_rc ? 4 : 2; end
             end
          2: begin
               m_cnt++;
               if (m_cnt >= model_dly && !model_hang) begin model_dr = 1'b1; m_cnt = 0; m_phase = 3; end
             end
          3: begin
               model_dr = 1'b0; m_cnt++;
               if (m_cnt == 2) begin model_idle = 1'b1; m_phase = 0; end
             end
          4: begin
               m_cnt++;
               if (m_cnt == 5) begin model_idle = 1'b1; m_phase = 0; end
             end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // At most one request may be high in any cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        checks++;
        if ((32'(bus.req_adc1) + 32'(bus.req_adc2) + 32'(bus.req_reconfig)) > 1) begin
          failures++;
          $display("FAIL onehot_req actual=%b%b%b required=at most one high",
                   bus.req_adc1, bus.req_adc2, bus.req_reconfig);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // driver: apply inputs before a rising edge, then settle after it
  task automatic step(input logic en_i, input logic [15:0] per_i, input logic [1:0] m_i,
                      input logic rr_i, input logic id_i, input logic dr_i, input logic ec_i);
    @(negedge clk);
    enable = en_i; period = per_i; chan_mask = m_i; reconfig_req = rr_i;
    drv_idle = id_i; drv_dr = dr_i; err_clr = ec_i;
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0: cond = bus.req_adc1;
      1: cond = bus.req_adc2;
      2: cond = (state_dbg == 3'd4);
      3: cond = scan_done;
      4: cond = busy;
      5: cond = !busy;
      default: cond = 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cond(sel) && n < budget);
    checks++;
    if (!cond(sel)) begin
      failures++;
      $display("FAIL %s actual=not seen required=seen within %0d cycles", name, budget);
    end
  endtask

  typedef struct {
    logic en; logic [15:0] per; logic [1:0] mask; logic rr; logic id; logic dr;
    logic r1; logic r2; logic rc; logic bsy; logic sd; logic rd; logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic en, input logic [15:0] per, input logic [1:0] mask,
                              input logic rr, input logic id, input logic dr,
                              input logic r1, input logic r2, input logic rc, input logic bsy,
                              input logic sd, input logic rd, input logic [15:0] cnt);
    vec_t v;
    v.en = en; v.per = per; v.mask = mask; v.rr = rr; v.id = id; v.dr = dr;
    v.r1 = r1; v.r2 = r2; v.rc = rc; v.bsy = bsy; v.sd = sd; v.rd = rd; v.cnt = cnt;
    return v;
  endfunction

  vec_t vecs[37];

  initial begin
    int n_sd, cyc, last_sd, rc_rise, rd_cnt, post, cdata;
    logic seen1, seen2, prev1, prev2, prev_rc, sd_seen;

    //          en per  mask rr id dr | r1 r2 rc bsy sd rd cnt
    // reconfig handshake
    vecs[0]  = mk(0, 0, 2'b00, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 2'b00, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0);
    vecs[2]  = mk(0, 0, 2'b00, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    vecs[4]  = mk(0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0, 1, 0);
    vecs[6]  = mk(0, 0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    // period 3, both channels
    vecs[8]  = mk(1, 3, 2'b11, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 3, 2'b11, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 3, 2'b11, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 3, 2'b11, 0, 1, 0,  1, 0, 0, 1, 0, 0, 0);
    vecs[12] = mk(0, 3, 2'b11, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    vecs[13] = mk(0, 3, 2'b11, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    vecs[14] = mk(0, 3, 2'b11, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0);
    vecs[15] = mk(0, 3, 2'b11, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    vecs[16] = mk(0, 3, 2'b11, 0, 1, 0,  0, 1, 0, 1, 0, 0, 0);
    vecs[17] = mk(0, 3, 2'b11, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0);
    vecs[18] = mk(0, 3, 2'b11, 0, 0, 1,  0, 0, 0, 1, 0, 0, 0);
    vecs[19] = mk(0, 3, 2'b11, 0, 1, 0,  0, 0, 0, 0, 1, 0, 1);
    vecs[20] = mk(0, 3, 2'b11, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1);
    // period 1, ADC2 only
    vecs[21] = mk(1, 1, 2'b10, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    vecs[22] = mk(0, 1, 2'b10, 0, 1, 0,  0, 1, 0, 1, 0, 0, 1);
    vecs[23] = mk(0, 1, 2'b10, 0, 0, 0,  0, 0, 0, 1, 0, 0, 1);
    vecs[24] = mk(0, 1, 2'b10, 0, 0, 1,  0, 0, 0, 1, 0, 0, 1);
    vecs[25] = mk(0, 1, 2'b10, 0, 1, 0,  0, 0, 0, 0, 1, 0, 2);
    // period 0 (acts as 1), empty mask
    vecs[26] = mk(1, 0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0, 0, 2);
    vecs[27] = mk(0, 0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0, 0, 2);
    vecs[28] = mk(0, 0, 2'b00, 0, 1, 0,  0, 0, 0, 0, 0, 0, 2);
    // tick and reconfig together: reconfig first, then ADC1 scan
    vecs[29] = mk(1, 1, 2'b01, 1, 1, 0,  0, 0, 0, 0, 0, 0, 2);
    vecs[30] = mk(0, 1, 2'b01, 0, 1, 0,  0, 0, 1, 1, 0, 0, 2);
    vecs[31] = mk(0, 1, 2'b01, 0, 0, 0,  0, 0, 0, 1, 0, 0, 2);
    vecs[32] = mk(0, 1, 2'b01, 0, 1, 0,  0, 0, 0, 0, 0, 1, 2);
    vecs[33] = mk(0, 1, 2'b01, 0, 1, 0,  1, 0, 0, 1, 0, 0, 2);
    vecs[34] = mk(0, 1, 2'b01, 0, 0, 0,  0, 0, 0, 1, 0, 0, 2);
    vecs[35] = mk(0, 1, 2'b01, 0, 0, 1,  0, 0, 0, 1, 0, 0, 2);
    vecs[36] = mk(0, 1, 2'b01, 0, 1, 0,  0, 0, 0, 0, 1, 0, 3);

    // reset values
    repeat (3) @(negedge clk);
    check("rst_req1", bus.req_adc1, 0);
    check("rst_req2", bus.req_adc2, 0);
    check("rst_rcfg", bus.req_reconfig, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", sample_cnt, 0);
    check("rst_terr", timeout_err, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;

    for (int i = 0; i < 37; i++) begin
      step(vecs[i].en, vecs[i].per, vecs[i].mask, vecs[i].rr, vecs[i].id, vecs[i].dr, 1'b0);
      check($sformatf("v%0d_req1", i), bus.req_adc1, vecs[i].r1);
      check($sformatf("v%0d_req2", i), bus.req_adc2, vecs[i].r2);
      check($sformatf("v%0d_rcfg", i), bus.req_reconfig, vecs[i].rc);
      check($sformatf("v%0d_busy", i), busy, vecs[i].bsy);
      check($sformatf("v%0d_scan_done", i), scan_done, vecs[i].sd);
      check($sformatf("v%0d_rcfg_done", i), reconfig_done, vecs[i].rd);
      check($sformatf("v%0d_cnt", i), sample_cnt, vecs[i].cnt);
    end
    check("tbl_ovr", overrun, 0);
    check("tbl_terr", timeout_err, 0);

    // asynchronous reset while req_adc2 is high
    use_model = 1'b1; model_hang = 1'b0; model_dly = 10;
    @(negedge clk);
    chan_mask = 2'b10; period = 16'd10; enable = 1'b1;
    wait_cond(1, 100, "t6_wait_req2");
    #2 rst = 1'b1;
    #1;
    check("t6_async_req2", bus.req_adc2, 0);
    check("t6_busy", busy, 0);
    check("t6_cnt", sample_cnt, 0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // periodic scanning, period 100, both channels
    chan_mask = 2'b11; period = 16'd100; enable = 1'b1;
    n_sd = 0; cyc = 0; last_sd = 0; seen1 = 0; seen2 = 0; prev1 = 0; prev2 = 0;
    while (n_sd < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.req_adc1 && !prev1) seen1 = 1'b1;
      if (bus.req_adc2 && !prev2) begin
        seen2 = 1'b1;
        check("t1_order_adc1_first", seen1, 1);
      end
      prev1 = bus.req_adc1; prev2 = bus.req_adc2;
      if (scan_done) begin
        n_sd++;
        check($sformatf("t1_cnt%0d", n_sd), sample_cnt, n_sd);
        check($sformatf("t1_both%0d", n_sd), {seen1, seen2}, 2'b11);
        if (n_sd > 1) check($sformatf("t1_interval%0d", n_sd), cyc - last_sd, 100);
        last_sd = cyc; seen1 = 0; seen2 = 0;
      end
    end
    check("t1_scans", n_sd, 3);

    // reconfig during ADC1 conversion waits for the scan
    wait_cond(0, 200, "t2_wait_req1");
    wait_cond(2, 20, "t2_wait_cdata");
    reconfig_req = 1'b1;
    @(negedge clk);
    reconfig_req = 1'b0;
    sd_seen = 0; rc_rise = 0; rd_cnt = 0; post = -1; prev_rc = 0;
    for (int c = 0; c < 300 && post != 0; c++) begin
      @(negedge clk);
      if (scan_done) sd_seen = 1'b1;
      if (bus.req_reconfig && !prev_rc) begin
        rc_rise++;
        check("t2_rcfg_after_scan", sd_seen, 1);
      end
      prev_rc = bus.req_reconfig;
      if (reconfig_done) rd_cnt++;
      if (post > 0) post--;
      else if (post < 0 && rd_cnt > 0) post = 10;
    end
    check("t2_rcfg_done_once", rd_cnt, 1);
    check("t2_rcfg_req_once", rc_rise, 1);
    enable = 1'b0;
    wait_cond(5, 200, "t2_idle");

    // watchdog on a conversion that never returns data
    rst = 1'b1;
    @(negedge clk);
    use_model = 1'b1; model_hang = 1'b1;
    rst = 1'b0;
    chan_mask = 2'b01; period = 16'd3; enable = 1'b1;
    wait_cond(4, 20, "t3_busy");
    enable = 1'b0;
    wait_cond(2, 20, "t3_cdata");
    cdata = 1; sd_seen = 0;
    for (int c = 0; c < 200 && state_dbg == 3'd4; c++) begin
      @(negedge clk);
      if (scan_done) sd_seen = 1'b1;
      if (state_dbg == 3'd4) cdata++;
    end
    check("t3_cdata_cycles", cdata, 49);
    check("t3_terr", timeout_err, 1);
    check("t3_req1", bus.req_adc1, 0);
    check("t3_busy", busy, 0);
    check("t3_cnt", sample_cnt, 0);
    check("t3_no_scan_done", sd_seen, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t3_err_clr", timeout_err, 0);
    use_model = 1'b0; model_hang = 1'b0;

    // watchdog on a reconfig that is never acknowledged; it is retried
    step(0, 0, 2'b00, 1, 1, 0, 0);
    step(0, 0, 2'b00, 0, 1, 0, 0);
    check("t3r_req", bus.req_reconfig, 1);
    repeat (48) step(0, 0, 2'b00, 0, 1, 0, 0);
    check("t3r_req_hold", bus.req_reconfig, 1);
    step(0, 0, 2'b00, 0, 1, 0, 0);
    check("t3r_req_dropped", bus.req_reconfig, 0);
    check("t3r_terr", timeout_err, 1);
    check("t3r_busy", busy, 0);
    step(0, 0, 2'b00, 0, 1, 0, 0);
    check("t3r_retry", bus.req_reconfig, 1);
    step(0, 0, 2'b00, 0, 0, 0, 0);
    step(0, 0, 2'b00, 0, 1, 0, 0);
    check("t3r_done", reconfig_done, 1);
    step(0, 0, 2'b00, 0, 1, 0, 1);
    check("t3r_err_clr", timeout_err, 0);

    // overrun: period 5 with ~21-cycle scans
    use_model = 1'b1; model_dly = 15;
    @(negedge clk);
    chan_mask = 2'b01; period = 16'd5; enable = 1'b1;
    n_sd = 0;
    repeat (100) begin
      @(negedge clk);
      if (scan_done) n_sd++;
    end
    check("t4_scans_continue", (n_sd >= 3), 1);
    check("t4_overrun", overrun, 1);
    wait_cond(3, 60, "t4_wait_done");
    enable = 1'b0;
    n_sd = 0;
    repeat (100) begin
      @(negedge clk);
      if (scan_done) n_sd++;
    end
    check("t4_one_queued", n_sd, 1);
    check("t4_idle", busy, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_ovr_clr", overrun, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
